// File: rtl/coh_vc_buffer_pkg.sv
// ============================================================================
// Module   : coh_vc_buffer_pkg
// Brief    : Shared constants and types for the coh_noc virtual-channel buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package coh_vc_buffer_pkg;

    localparam int VC_BUFFER_DEPTH = 16;

    localparam int VC_REQ = 0;
    localparam int VC_RSP = 1;
    localparam int VC_DAT = 2;
    localparam int VC_SNP = 3;

    typedef enum logic [0:0] {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    function automatic int vc_width(input int num_vc);
        return (num_vc > 1) ? $clog2(num_vc) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/coh_vc_buffer_if.sv
// ============================================================================
// Module   : coh_vc_buffer_if
// Brief    : Credit-controlled input and valid/ready output of the VC buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface coh_vc_buffer_if #(
    parameter int NUM_VC = 4,
    parameter int VC_W   = 2,
    parameter int FLIT_W = 731
);
    logic              in_valid;
    logic [VC_W-1:0]   in_vc;
    logic [FLIT_W-1:0] in_flit;
    logic [NUM_VC-1:0] crd_rtn;
    logic              out_valid;
    logic [VC_W-1:0]   out_vc;
    logic [FLIT_W-1:0] out_flit;
    logic              out_ready;

    modport master (
        output in_valid, in_vc, in_flit, out_ready,
        input  crd_rtn, out_valid, out_vc, out_flit
    );

    modport slave (
        input  in_valid, in_vc, in_flit, out_ready,
        output crd_rtn, out_valid, out_vc, out_flit
    );
endinterface

`default_nettype wire

// File: rtl/coh_vc_rr_arbiter.sv
// ============================================================================
// Module   : coh_vc_rr_arbiter
// Brief    : Round-robin or fixed-priority VC arbiter with one-hot grant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module coh_vc_rr_arbiter
    import coh_vc_buffer_pkg::*;
#(
    parameter int NUM_VC   = 4,
    parameter int VC_W     = 2,
    parameter int ARB_MODE = 0
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic [NUM_VC-1:0] req,
    input  wire logic              advance,
    input  wire logic [VC_W-1:0]   adv_vc,
    output logic      [NUM_VC-1:0] gnt,
    output logic      [VC_W-1:0]   gnt_idx
);

    localparam arb_mode_e c_mode = arb_mode_e'(ARB_MODE[0]);

    logic [VC_W-1:0] r_rr_ptr;
    logic [VC_W-1:0] w_base;
    logic            w_found;
    int              w_idx;

    // On a transfer the search already starts past the VC just served,
    // so the refill issued at the same edge honours the new pointer.
    always_comb begin
        w_base = r_rr_ptr;
        if (advance) begin
            w_base = (int'(adv_vc) == NUM_VC - 1) ? '0 : adv_vc + VC_W'(1);
        end
    end

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (c_mode == ARB_FIXED) begin
                w_idx = i;
            end else begin
                w_idx = (int'(w_base) + i) % NUM_VC;
            end
            if (!w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                gnt_idx    = VC_W'(w_idx);
                w_found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (advance) begin
            r_rr_ptr <= w_base;
        end
    end

endmodule

`default_nettype wire

// File: rtl/coh_vc_buffer.sv
// ============================================================================
// Module   : coh_vc_buffer
// Brief    : Multi-VC credit-returning input buffer with arbitrated output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module coh_vc_buffer
    import coh_vc_buffer_pkg::*;
#(
    parameter int NUM_VC   = 4,
    parameter int DEPTH    = VC_BUFFER_DEPTH,
    parameter int FLIT_W   = 731,
    parameter int ARB_MODE = 0,
    parameter int VC_W     = vc_width(NUM_VC),
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    coh_vc_buffer_if.slave               bus,
    output logic [NUM_VC*CNT_W-1:0]      vc_count,
    output logic                         overflow_err
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0]  w_cnt  [NUM_VC];
    logic [FLIT_W-1:0] w_head [NUM_VC];
    logic [NUM_VC-1:0] w_wr;
    logic [NUM_VC-1:0] w_deq;
    logic [NUM_VC-1:0] w_req;
    logic [NUM_VC-1:0] w_gnt;
    logic [VC_W-1:0]   w_gnt_idx;
    logic              w_accept;
    logic              w_load;
    logic              w_drop;

    logic              r_out_valid;
    logic [VC_W-1:0]   r_out_vc;
    logic [FLIT_W-1:0] r_out_flit;
    logic [NUM_VC-1:0] r_crd;
    logic              r_ovf;

    function automatic logic [c_ptr_w-1:0] ptr_next(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
    endfunction

    assign w_accept = r_out_valid && bus.out_ready;
    assign w_load   = !r_out_valid || bus.out_ready;
    assign w_drop   = bus.in_valid && !(|w_wr);

    // The presented flit stays in its FIFO until accepted; the refill view
    // (request and head) looks one entry past it on the dequeuing VC.
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        logic [FLIT_W-1:0]  r_mem [DEPTH];
        logic [c_ptr_w-1:0] r_wr_ptr;
        logic [c_ptr_w-1:0] r_rd_ptr;
        logic [CNT_W-1:0]   r_cnt;
        logic [c_ptr_w-1:0] w_rd_eff;

        assign w_wr[v]   = bus.in_valid && (int'(bus.in_vc) == v) && (r_cnt != CNT_W'(DEPTH));
        assign w_deq[v]  = w_accept && (int'(r_out_vc) == v);
        assign w_rd_eff  = w_deq[v] ? ptr_next(r_rd_ptr) : r_rd_ptr;
        assign w_req[v]  = w_deq[v] ? (r_cnt > CNT_W'(1)) : (r_cnt != '0);
        assign w_head[v] = r_mem[w_rd_eff];
        assign w_cnt[v]  = r_cnt;
        assign vc_count[v*CNT_W +: CNT_W] = r_cnt;

        always_ff @(posedge clk) begin
            if (w_wr[v]) begin
                r_mem[r_wr_ptr] <= bus.in_flit;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_cnt    <= '0;
            end else begin
                if (w_wr[v]) begin
                    r_wr_ptr <= ptr_next(r_wr_ptr);
                end
                if (w_deq[v]) begin
                    r_rd_ptr <= ptr_next(r_rd_ptr);
                end
                case ({w_wr[v], w_deq[v]})
                    2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                    2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

    coh_vc_rr_arbiter #(
        .NUM_VC   (NUM_VC),
        .VC_W     (VC_W),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (w_req),
        .advance (w_accept),
        .adv_vc  (r_out_vc),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_vc    <= '0;
            r_out_flit  <= '0;
            r_crd       <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_crd <= w_deq;
            if (w_load) begin
                r_out_valid <= |w_gnt;
                if (|w_gnt) begin
                    r_out_vc   <= w_gnt_idx;
                    r_out_flit <= w_head[w_gnt_idx];
                end
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_vc    = r_out_vc;
    assign bus.out_flit  = r_out_flit;
    assign bus.crd_rtn   = r_crd;
    assign overflow_err  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_coh_vc_buffer.sv
// ============================================================================
// Module   : tb_coh_vc_buffer
// Brief    : Scoreboard bench for coh_vc_buffer (RR, fixed-priority, DEPTH=5).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_coh_vc_buffer;
    import coh_vc_buffer_pkg::*;

    localparam int FW = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int sel      = 0;

    logic          tb_in_valid = 1'b0;
    logic [1:0]    tb_in_vc    = '0;
    logic [FW-1:0] tb_in_flit  = '0;
    logic          tb_ready    = 1'b0;

    coh_vc_buffer_if #(.NUM_VC(4), .VC_W(2), .FLIT_W(FW)) bus_rr ();
    coh_vc_buffer_if #(.NUM_VC(4), .VC_W(2), .FLIT_W(FW)) bus_fx ();
    coh_vc_buffer_if #(.NUM_VC(4), .VC_W(2), .FLIT_W(FW)) bus_d5 ();

    assign bus_rr.in_valid  = tb_in_valid && (sel == 0);
    assign bus_rr.in_vc     = tb_in_vc;
    assign bus_rr.in_flit   = tb_in_flit;
    assign bus_rr.out_ready = tb_ready && (sel == 0);
    assign bus_fx.in_valid  = tb_in_valid && (sel == 1);
    assign bus_fx.in_vc     = tb_in_vc;
    assign bus_fx.in_flit   = tb_in_flit;
    assign bus_fx.out_ready = tb_ready && (sel == 1);
    assign bus_d5.in_valid  = tb_in_valid && (sel == 2);
    assign bus_d5.in_vc     = tb_in_vc;
    assign bus_d5.in_flit   = tb_in_flit;
    assign bus_d5.out_ready = tb_ready && (sel == 2);

    logic [19:0] cnt_rr, cnt_fx;
    logic [11:0] cnt_d5;
    logic        ovf_rr, ovf_fx, ovf_d5;

    coh_vc_buffer #(.NUM_VC(4), .DEPTH(16), .FLIT_W(FW), .ARB_MODE(0)) dut_rr (
        .clk(clk), .rst_n(rst_n), .bus(bus_rr), .vc_count(cnt_rr), .overflow_err(ovf_rr));
    coh_vc_buffer #(.NUM_VC(4), .DEPTH(16), .FLIT_W(FW), .ARB_MODE(1)) dut_fx (
        .clk(clk), .rst_n(rst_n), .bus(bus_fx), .vc_count(cnt_fx), .overflow_err(ovf_fx));
    coh_vc_buffer #(.NUM_VC(4), .DEPTH(5), .FLIT_W(FW), .ARB_MODE(0)) dut_d5 (
        .clk(clk), .rst_n(rst_n), .bus(bus_d5), .vc_count(cnt_d5), .overflow_err(ovf_d5));

    logic          m_valid;
    logic [1:0]    m_vc;
    logic [FW-1:0] m_flit;
    logic [3:0]    m_crd;
    logic          m_ovf;
    int            m_cnt [4];

    always_comb begin
        m_valid = bus_rr.out_valid;
        m_vc    = bus_rr.out_vc;
        m_flit  = bus_rr.out_flit;
        m_crd   = bus_rr.crd_rtn;
        m_ovf   = ovf_rr;
        for (int v = 0; v < 4; v++) m_cnt[v] = int'(cnt_rr[v*5 +: 5]);
        if (sel == 1) begin
            m_valid = bus_fx.out_valid;
            m_vc    = bus_fx.out_vc;
            m_flit  = bus_fx.out_flit;
            m_crd   = bus_fx.crd_rtn;
            m_ovf   = ovf_fx;
            for (int v = 0; v < 4; v++) m_cnt[v] = int'(cnt_fx[v*5 +: 5]);
        end else if (sel == 2) begin
            m_valid = bus_d5.out_valid;
            m_vc    = bus_d5.out_vc;
            m_flit  = bus_d5.out_flit;
            m_crd   = bus_d5.crd_rtn;
            m_ovf   = ovf_d5;
            for (int v = 0; v < 4; v++) m_cnt[v] = int'(cnt_d5[v*3 +: 3]);
        end
    end

    // Scoreboard: entries are {vc, flit} in the order they must leave.
    logic [FW+1:0] exp_q [$];
    logic [FW+1:0] exp_e;
    logic [3:0]    prev_acc = '0;
    int            crd_pulses [4] = '{0, 0, 0, 0};

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_acc = '0;
        end else begin
            checks++;
            if (m_crd !== prev_acc) begin
                failures++;
                $display("FAIL crd_rtn sel=%0d: got %b required %b", sel, m_crd, prev_acc);
            end
            for (int v = 0; v < 4; v++) if (m_crd[v]) crd_pulses[v]++;
            prev_acc = '0;
            if (m_valid === 1'b1 && tb_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL out_unexpected sel=%0d: got vc=%0d flit=%h required none", sel, m_vc, m_flit);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({m_vc, m_flit} !== exp_e) begin
                        failures++;
                        $display("FAIL out_order sel=%0d: got vc=%0d flit=%h required vc=%0d flit=%h",
                                 sel, m_vc, m_flit, exp_e[FW+1:FW], exp_e[FW-1:0]);
                    end
                end
                prev_acc = 4'b0001 << m_vc;
            end
        end
    end

    function automatic logic [FW-1:0] mk(int tag, int vc, int k);
        return {16'hC0DE, 8'(tag), 8'(vc), 32'(k)};
    endfunction

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put(int vc, logic [FW-1:0] f);
        tb_in_valid = 1'b1;
        tb_in_vc    = 2'(vc);
        tb_in_flit  = f;
        step();
        tb_in_valid = 1'b0;
    endtask

    task automatic wait_empty(string name, int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: got %0d flits left required 0", name, exp_q.size());
            exp_q.delete();
        end
        step(3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++;
            if ({m_valid, m_vc, m_flit, m_crd, m_ovf} !== '0) begin
                failures++;
                $display("FAIL reset_outputs sel=%0d: got v=%b vc=%0d flit=%h crd=%b ovf=%b required all 0",
                         s, m_valid, m_vc, m_flit, m_crd, m_ovf);
            end
            checks++;
            if (m_cnt[0] + m_cnt[1] + m_cnt[2] + m_cnt[3] !== 0) begin
                failures++;
                $display("FAIL reset_count sel=%0d: got %0d/%0d/%0d/%0d required 0", s,
                         m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]);
            end
        end
        sel = 0;
        step();
    endtask

    task automatic test_hold_drain();
        logic [FW-1:0] fa;
        fa = mk(1, VC_DAT, 0);
        sel = 0;
        tb_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            put(VC_DAT, mk(1, VC_DAT, k));
            exp_q.push_back({2'(VC_DAT), mk(1, VC_DAT, k)});
        end
        checks++;
        if (m_cnt[VC_DAT] !== 3) begin
            failures++;
            $display("FAIL hold_count: got %0d required 3", m_cnt[VC_DAT]);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (m_valid !== 1'b1 || m_vc !== 2'(VC_DAT) || m_flit !== fa) begin
                failures++;
                $display("FAIL hold_stable: got v=%b vc=%0d flit=%h required v=1 vc=2 flit=%h",
                         m_valid, m_vc, m_flit, fa);
            end
        end
        crd_pulses = '{0, 0, 0, 0};
        tb_ready = 1'b1;
        wait_empty("hold", 20);
        checks++;
        if (crd_pulses[VC_DAT] !== 3 || crd_pulses[0] + crd_pulses[1] + crd_pulses[3] !== 0) begin
            failures++;
            $display("FAIL hold_credits: got vc2=%0d others=%0d required vc2=3 others=0",
                     crd_pulses[VC_DAT], crd_pulses[0] + crd_pulses[1] + crd_pulses[3]);
        end
        checks++;
        if (m_valid !== 1'b0 || m_cnt[VC_DAT] !== 0) begin
            failures++;
            $display("FAIL hold_empty: got v=%b cnt=%0d required v=0 cnt=0", m_valid, m_cnt[VC_DAT]);
        end
        tb_ready = 1'b0;
    endtask

    task automatic test_overflow();
        sel = 0;
        tb_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            put(VC_REQ, mk(2, VC_REQ, k));
            exp_q.push_back({2'(VC_REQ), mk(2, VC_REQ, k)});
        end
        checks++;
        if (m_cnt[VC_REQ] !== 16 || m_ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_full: got cnt=%0d ovf=%b required cnt=16 ovf=0", m_cnt[VC_REQ], m_ovf);
        end
        put(VC_REQ, mk(2, VC_REQ, 99));
        step();
        checks++;
        if (m_cnt[VC_REQ] !== 16 || m_ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_drop: got cnt=%0d ovf=%b required cnt=16 ovf=1", m_cnt[VC_REQ], m_ovf);
        end
        tb_ready = 1'b1;
        wait_empty("ovf", 40);
        checks++;
        if (m_ovf !== 1'b1 || m_cnt[VC_REQ] !== 0) begin
            failures++;
            $display("FAIL ovf_sticky: got ovf=%b cnt=%0d required ovf=1 cnt=0", m_ovf, m_cnt[VC_REQ]);
        end
        tb_ready = 1'b0;
    endtask

    task automatic fill_two_each(int tag);
        tb_ready = 1'b0;
        for (int k = 0; k < 2; k++)
            for (int v = 0; v < 4; v++)
                put(v, mk(tag, v, k));
    endtask

    task automatic test_rr_order();
        sel = 0;
        fill_two_each(3);
        for (int k = 0; k < 2; k++)
            for (int v = 0; v < 4; v++)
                exp_q.push_back({2'(v), mk(3, v, k)});
        tb_ready = 1'b1;
        wait_empty("rr", 30);
        tb_ready = 1'b0;
    endtask

    task automatic test_fixed_order();
        sel = 1;
        step();
        fill_two_each(4);
        for (int v = 0; v < 4; v++)
            for (int k = 0; k < 2; k++)
                exp_q.push_back({2'(v), mk(4, v, k)});
        tb_ready = 1'b1;
        wait_empty("fixed", 30);
        tb_ready = 1'b0;
    endtask

    task automatic test_wrap();
        sel = 2;
        step();
        tb_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            put(VC_RSP, mk(5, VC_RSP, k));
            exp_q.push_back({2'(VC_RSP), mk(5, VC_RSP, k)});
        end
        checks++;
        if (m_cnt[VC_RSP] !== 4) begin
            failures++;
            $display("FAIL wrap_fill: got %0d required 4", m_cnt[VC_RSP]);
        end
        tb_ready = 1'b1;
        for (int k = 4; k < 12; k++) begin
            put(VC_RSP, mk(5, VC_RSP, k));
            exp_q.push_back({2'(VC_RSP), mk(5, VC_RSP, k)});
        end
        checks++;
        if (m_cnt[VC_RSP] !== 4) begin
            failures++;
            $display("FAIL wrap_steady: got %0d required 4", m_cnt[VC_RSP]);
        end
        wait_empty("wrap", 20);
        checks++;
        if (m_ovf !== 1'b0 || m_cnt[VC_RSP] !== 0) begin
            failures++;
            $display("FAIL wrap_end: got ovf=%b cnt=%0d required ovf=0 cnt=0", m_ovf, m_cnt[VC_RSP]);
        end
        tb_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        sel = 0;
        step();
        tb_ready = 1'b0;
        put(VC_REQ, mk(6, 0, 0));
        put(VC_SNP, mk(6, 3, 0));
        put(VC_DAT, mk(6, 2, 0));
        put(VC_REQ, mk(6, 0, 1));
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_vc, m_flit, m_crd, m_ovf} !== '0 ||
            m_cnt[0] + m_cnt[1] + m_cnt[2] + m_cnt[3] !== 0) begin
            failures++;
            $display("FAIL midreset_outputs: got v=%b vc=%0d flit=%h ovf=%b cnt0=%0d required all 0",
                     m_valid, m_vc, m_flit, m_ovf, m_cnt[0]);
        end
        step(2);
        rst_n = 1'b1;
        tb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (m_valid !== 1'b0) begin
                failures++;
                $display("FAIL midreset_idle: got out_valid=%b required 0", m_valid);
            end
        end
        put(VC_SNP, mk(7, 3, 0));
        exp_q.push_back({2'(VC_SNP), mk(7, 3, 0)});
        wait_empty("midreset", 10);
        tb_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hold_drain();
        test_overflow();
        test_rr_order();
        test_fixed_order();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
